// File: rtl/issue_pkg.sv
// Shared definitions for the ID-stage issue controller: opcodes, control
// bundle layout, the bubble constant and the issue FSM states.
package issue_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam int WB_W = 2;
  localparam int M_W  = 3;
  localparam int EX_W = 4;

  // Bit indices inside each bundle
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int M_BRANCH    = 2;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;
  localparam int EX_REGDST   = 3;
  localparam int EX_ALUOP_HI = 2;
  localparam int EX_ALUOP_LO = 1;
  localparam int EX_ALUSRC   = 0;

  typedef struct packed {
    logic [WB_W-1:0] wb;
    logic [M_W-1:0]  m;
    logic [EX_W-1:0] ex;
  } ctrl_t;

  localparam logic [WB_W-1:0] BUBBLE_WB = '0;
  localparam logic [M_W-1:0]  BUBBLE_M  = '0;
  localparam logic [EX_W-1:0] BUBBLE_EX = '0;
  localparam ctrl_t           BUBBLE    = '{wb: BUBBLE_WB, m: BUBBLE_M, ex: BUBBLE_EX};

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LDSTALL,
    ST_FLUSH
  } state_e;

endpackage

// File: rtl/id_issue_ctrl_if.sv
// IF/ID-to-issue-controller handshake bundle. The master side supplies the
// instruction and hazard inputs; the slave side (the controller) returns the
// ID/EX control bundle and the pipeline write enables.
interface id_issue_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]                  inst_ID;
  logic                         inst_valid_ID;
  logic                         br_taken_MEM;
  logic                         mem_busy;
  logic [issue_pkg::WB_W-1:0]   ctrl_WB;
  logic [issue_pkg::M_W-1:0]    ctrl_M;
  logic [issue_pkg::EX_W-1:0]   ctrl_EX;
  logic                         pc_write;
  logic                         ifid_write;
  logic                         ifid_flush;
  logic [CNT_W-1:0]             stall_cnt;

  modport master (
    output inst_ID, inst_valid_ID, br_taken_MEM, mem_busy,
    input  ctrl_WB, ctrl_M, ctrl_EX, pc_write, ifid_write, ifid_flush, stall_cnt
  );

  modport slave (
    input  inst_ID, inst_valid_ID, br_taken_MEM, mem_busy,
    output ctrl_WB, ctrl_M, ctrl_EX, pc_write, ifid_write, ifid_flush, stall_cnt
  );
endinterface

// File: rtl/id_ctrl_decode.sv
// Opcode decoder: maps the major opcode to the WB/M/EX control bundle and
// flags opcodes that read rt as a source operand.
module id_ctrl_decode
  import issue_pkg::*;
(
  input  logic [5:0] op,
  input  logic       valid,
  output ctrl_t      ctrl,
  output logic       uses_rt
);

  // Table lookup; unknown opcodes and invalid slots decode to a bubble
  always_comb begin
    ctrl    = BUBBLE;
    uses_rt = 1'b0;
    case (op)
      OP_RTYPE: begin
        ctrl    = '{wb: 2'b10, m: 3'b000, ex: 4'b1100};
        uses_rt = 1'b1;
      end
      OP_LW:   ctrl = '{wb: 2'b11, m: 3'b010, ex: 4'b0001};
      OP_SW: begin
        ctrl    = '{wb: 2'b00, m: 3'b001, ex: 4'b0001};
        uses_rt = 1'b1;
      end
      OP_BEQ: begin
        ctrl    = '{wb: 2'b00, m: 3'b100, ex: 4'b0010};
        uses_rt = 1'b1;
      end
      OP_ADDI: ctrl = '{wb: 2'b10, m: 3'b000, ex: 4'b0001};
      default: ctrl = BUBBLE;
    endcase
    if (!valid) ctrl = BUBBLE;
  end

endmodule

// File: rtl/id_issue_ctrl.sv
// ID-stage issue controller: decodes the IF/ID instruction into the ID/EX
// control bundle, stalls on load-use hazards against the previously issued
// entry, and inserts bubbles after taken branches.
// Optional bubble counter enabled by defining ISSUE_STALL_CNT_EN.
module id_issue_ctrl
  import issue_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input logic           clk_ISSUE,
  input logic           rst_ISSUE,
  id_issue_ctrl_if.slave bus
);

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       unused_imm;
  ctrl_t      dec;
  logic       uses_rt;

  state_e     state_q, state_d;
  logic [2:0] flush_q, flush_d;
  logic       ex_memread_q;
  logic [4:0] ex_rt_q;

  logic       load_use;
  logic       force_bubble;
  logic       pc_w, ifid_w, ifid_fl;
  ctrl_t      issued;

  assign op         = bus.inst_ID[31:26];
  assign rs         = bus.inst_ID[25:21];
  assign rt         = bus.inst_ID[20:16];
  assign unused_imm = ^bus.inst_ID[15:0];

  id_ctrl_decode u_dec (
    .op      (op),
    .valid   (bus.inst_valid_ID),
    .ctrl    (dec),
    .uses_rt (uses_rt)
  );

  assign load_use = ex_memread_q && (ex_rt_q != 5'd0) &&
                    ((ex_rt_q == rs) || ((ex_rt_q == rt) && uses_rt));

  // Next-state and issue decision; priority branch > memory hold > load-use
  always_comb begin
    force_bubble = 1'b0;
    pc_w         = 1'b1;
    ifid_w       = 1'b1;
    ifid_fl      = 1'b0;
    state_d      = state_q;
    flush_d      = flush_q;
    if (rst_ISSUE) begin
      force_bubble = 1'b1;
      pc_w         = 1'b0;
      ifid_w       = 1'b0;
    end else if (bus.br_taken_MEM) begin
      force_bubble = 1'b1;
      ifid_fl      = 1'b1;
      if (FLUSH_CYCLES > 0) begin
        state_d = ST_FLUSH;
        flush_d = 3'(FLUSH_CYCLES);
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      case (state_q)
        ST_FLUSH: begin
          force_bubble = 1'b1;
          // A memory hold freezes the front end and the remaining flush count
          if (bus.mem_busy) begin
            pc_w   = 1'b0;
            ifid_w = 1'b0;
          end else begin
            flush_d = flush_q - 3'd1;
            if (flush_q <= 3'd1) state_d = ST_RUN;
          end
        end
        ST_LDSTALL: begin
          // Shadow holds the bubble issued last cycle, so no load-use check
          state_d = ST_RUN;
          if (bus.mem_busy) begin
            force_bubble = 1'b1;
            pc_w         = 1'b0;
            ifid_w       = 1'b0;
          end
        end
        default: begin
          state_d = ST_RUN;
          if (bus.mem_busy) begin
            force_bubble = 1'b1;
            pc_w         = 1'b0;
            ifid_w       = 1'b0;
          end else if (load_use) begin
            force_bubble = 1'b1;
            pc_w         = 1'b0;
            ifid_w       = 1'b0;
            state_d      = ST_LDSTALL;
          end
        end
      endcase
    end
    issued = force_bubble ? BUBBLE : dec;
  end

  assign bus.ctrl_WB    = issued.wb;
  assign bus.ctrl_M     = issued.m;
  assign bus.ctrl_EX    = issued.ex;
  assign bus.pc_write   = pc_w;
  assign bus.ifid_write = ifid_w;
  assign bus.ifid_flush = ifid_fl;

  // FSM state, flush counter and shadow of the entry just issued to ID/EX
  always_ff @(posedge clk_ISSUE or posedge rst_ISSUE) begin
    if (rst_ISSUE) begin
      state_q      <= ST_RUN;
      flush_q      <= '0;
      ex_memread_q <= 1'b0;
      ex_rt_q      <= '0;
    end else begin
      state_q      <= state_d;
      flush_q      <= flush_d;
      ex_memread_q <= issued.m[M_MEMREAD];
      ex_rt_q      <= (force_bubble || !bus.inst_valid_ID) ? 5'd0 : rt;
    end
  end

`ifdef ISSUE_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Count bubbles inserted in place of a real instruction, saturating
  always_ff @(posedge clk_ISSUE or posedge rst_ISSUE) begin
    if (rst_ISSUE) begin
      cnt_q <= '0;
    end else if (force_bubble && bus.inst_valid_ID && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.stall_cnt = cnt_q;
`else
  assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Bench for id_issue_ctrl: two instances (FLUSH_CYCLES=1/CNT_W=32 and
// FLUSH_CYCLES=2/CNT_W=2) share one directed stimulus stream and are checked
// every cycle against a behavioural model, plus literal spot checks.
module tb_id_issue_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] inst;
  logic        valid;
  logic        br;
  logic        busy;

  int total = 0;
  int bad   = 0;

  id_issue_ctrl_if #(.CNT_W(32)) ifa ();
  id_issue_ctrl_if #(.CNT_W(2))  ifb ();

  assign ifa.inst_ID       = inst;
  assign ifa.inst_valid_ID = valid;
  assign ifa.br_taken_MEM  = br;
  assign ifa.mem_busy      = busy;
  assign ifb.inst_ID       = inst;
  assign ifb.inst_valid_ID = valid;
  assign ifb.br_taken_MEM  = br;
  assign ifb.mem_busy      = busy;

  id_issue_ctrl #(.FLUSH_CYCLES(1), .CNT_W(32)) dut_a (
    .clk_ISSUE (clk),
    .rst_ISSUE (rst),
    .bus       (ifa)
  );

  id_issue_ctrl #(.FLUSH_CYCLES(2), .CNT_W(2)) dut_b (
    .clk_ISSUE (clk),
    .rst_ISSUE (rst),
    .bus       (ifb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [8:0] ref_decode(input logic [5:0] o);
    case (o)
      6'b000000: return 9'b10_000_1100;
      6'b100011: return 9'b11_010_0001;
      6'b101011: return 9'b00_001_0001;
      6'b000100: return 9'b00_100_0010;
      6'b001000: return 9'b10_000_0001;
      default:   return 9'b0;
    endcase
  endfunction

  int               fl_cfg [2] = '{1, 2};
  longint unsigned  cmax   [2] = '{64'hFFFF_FFFF, 64'd3};
  logic [4:0]       m_ldrt [2] = '{5'd0, 5'd0};  // rt of the lw last issued, 0 if none
  int               m_fl   [2] = '{0, 0};        // flush bubbles still owed
  longint unsigned  m_cnt  [2] = '{0, 0};

  initial begin
    logic [11:0]     act_b [2];
    longint unsigned act_c [2];
    logic [8:0]      dec;
    logic            ut, lu, forced, e_pc, e_if, e_fl;
    logic [4:0]      rs, rt;
    longint unsigned e_cnt;
    forever begin
      @(negedge clk);
      act_b[0] = {ifa.ctrl_WB, ifa.ctrl_M, ifa.ctrl_EX, ifa.pc_write, ifa.ifid_write, ifa.ifid_flush};
      act_b[1] = {ifb.ctrl_WB, ifb.ctrl_M, ifb.ctrl_EX, ifb.pc_write, ifb.ifid_write, ifb.ifid_flush};
      act_c[0] = 64'(ifa.stall_cnt);
      act_c[1] = 64'(ifb.stall_cnt);
      dec = valid ? ref_decode(inst[31:26]) : 9'b0;
      ut  = inst[31:26] inside {6'b000000, 6'b101011, 6'b000100};
      rs  = inst[25:21];
      rt  = inst[20:16];
      for (int i = 0; i < 2; i++) begin
        lu = (m_ldrt[i] != 5'd0) && ((m_ldrt[i] == rs) || ((m_ldrt[i] == rt) && ut));
        forced = 1'b1; e_pc = 1'b1; e_if = 1'b1; e_fl = 1'b0;
        if (rst) begin
          e_pc = 1'b0; e_if = 1'b0;
        end else if (br) begin
          e_fl = 1'b1;
        end else if (m_fl[i] > 0) begin
          if (busy) begin e_pc = 1'b0; e_if = 1'b0; end
        end else if (busy || lu) begin
          e_pc = 1'b0; e_if = 1'b0;
        end else begin
          forced = 1'b0;
        end
`ifdef ISSUE_STALL_CNT_EN
        e_cnt = m_cnt[i];
`else
        e_cnt = 0;
`endif
        chk($sformatf("bundle%0d", i), 64'(act_b[i]), 64'({(forced ? 9'b0 : dec), e_pc, e_if, e_fl}));
        chk($sformatf("stall_cnt%0d", i), act_c[i], e_cnt);
        // advance the model to the next cycle
        if (rst) begin
          m_ldrt[i] = 5'd0; m_fl[i] = 0; m_cnt[i] = 0;
        end else begin
          if (br) m_fl[i] = fl_cfg[i];
          else if (m_fl[i] > 0 && !busy) m_fl[i]--;
          m_ldrt[i] = (!forced && valid && inst[31:26] == 6'b100011) ? rt : 5'd0;
          if (forced && valid && m_cnt[i] < cmax[i]) m_cnt[i]++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] s, input logic [4:0] t);
    return {6'b000000, s, t, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                                       input logic [15:0] imm);
    return {o, s, t, imm};
  endfunction

  task automatic drive(input logic [31:0] i, input logic v, input logic b, input logic mb);
    @(posedge clk);
    #1;
    inst = i; valid = v; br = b; busy = mb;
    @(negedge clk);
  endtask

  logic [31:0] LW8, ADD98, ADD312, ADDI9_8, ADDI8_3, SW8, BEQ8, LW0;

  initial begin
    LW8     = i_op(6'b100011, 5'd1, 5'd8, 16'd0);
    ADD98   = r_add(5'd9, 5'd8, 5'd2);
    ADD312  = r_add(5'd3, 5'd1, 5'd2);
    ADDI9_8 = i_op(6'b001000, 5'd8, 5'd9, 16'd1);
    ADDI8_3 = i_op(6'b001000, 5'd3, 5'd8, 16'd1);
    SW8     = i_op(6'b101011, 5'd4, 5'd8, 16'd0);
    BEQ8    = i_op(6'b000100, 5'd8, 5'd0, 16'd4);
    LW0     = i_op(6'b100011, 5'd1, 5'd0, 16'd0);

    rst = 1'b1; inst = '0; valid = 1'b0; br = 1'b0; busy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: reset asserted while a lw is being issued
    drive(ADD312, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1 inst = LW8; valid = 1'b1;
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outputs", 64'({ifa.ctrl_WB, ifa.ctrl_M, ifa.ctrl_EX, ifa.pc_write, ifa.ifid_write, ifa.ifid_flush}), 64'd0);
    drive(LW8, 1'b1, 1'b0, 1'b0);
    chk("rst_held_pc_write", 64'(ifa.pc_write), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0; inst = ADD98;
    @(negedge clk);
    chk("rst_cleared_shadow", 64'({ifa.pc_write, ifa.ctrl_WB}), 64'({1'b1, 2'b10}));

    // 2: lw $8 then add $9,$8,$2
    drive(LW8, 1'b1, 1'b0, 1'b0);
    chk("lw_issue_WB", 64'(ifa.ctrl_WB), 64'(2'b11));
    drive(ADD98, 1'b1, 1'b0, 1'b0);
    chk("lu_stall", 64'({ifa.pc_write, ifa.ifid_write, ifa.ctrl_WB, ifa.ctrl_EX}), 64'd0);
    drive(ADD98, 1'b1, 1'b0, 1'b0);
    chk("lu_release", 64'({ifa.pc_write, ifa.ctrl_WB, ifa.ctrl_EX}), 64'({1'b1, 2'b10, 4'b1100}));

    // 3: addi reading the load result stalls; addi writing it does not
    drive(LW8, 1'b1, 1'b0, 1'b0);
    drive(ADDI9_8, 1'b1, 1'b0, 1'b0);
    chk("addi_rs_stall", 64'(ifa.pc_write), 64'd0);
    drive(ADDI9_8, 1'b1, 1'b0, 1'b0);
    drive(LW8, 1'b1, 1'b0, 1'b0);
    drive(ADDI8_3, 1'b1, 1'b0, 1'b0);
    chk("addi_rt_no_stall", 64'({ifa.pc_write, ifa.ctrl_WB, ifa.ctrl_EX}), 64'({1'b1, 2'b10, 4'b0001}));

    // 4: taken branch, one extra flush bubble on instance A
    drive(ADD312, 1'b1, 1'b0, 1'b0);
    drive(ADD312, 1'b1, 1'b1, 1'b0);
    chk("br_flush_pulse", 64'({ifa.ifid_flush, ifa.pc_write, ifa.ctrl_WB}), 64'({1'b1, 1'b1, 2'b00}));
    drive(ADD312, 1'b1, 1'b0, 1'b0);
    chk("flush_bubble", 64'({ifa.ifid_flush, ifa.pc_write, ifa.ifid_write, ifa.ctrl_WB}), 64'({3'b011, 2'b00}));
    drive(ADD312, 1'b1, 1'b0, 1'b0);
    chk("flush_done", 64'(ifa.ctrl_WB), 64'(2'b10));
    drive(SW8, 1'b1, 1'b0, 1'b0);
    drive(BEQ8, 1'b1, 1'b0, 1'b0);

    // 5: branch and hold together during a load-use hazard
    drive(LW8, 1'b1, 1'b0, 1'b0);
    drive(ADD98, 1'b1, 1'b1, 1'b1);
    chk("br_over_busy_lu", 64'({ifa.pc_write, ifa.ifid_flush}), 64'({1'b1, 1'b1}));
    repeat (3) drive(ADD312, 1'b1, 1'b0, 1'b0);

    // Extra: hold alone, invalid slot, sw/beq rt hazards, lw to $0,
    // branch during LDSTALL, branch during FLUSH
    drive(ADD312, 1'b1, 1'b0, 1'b1);
    chk("busy_hold", 64'({ifa.pc_write, ifa.ifid_write}), 64'd0);
    drive(ADD312, 1'b0, 1'b0, 1'b0);
    drive(LW8, 1'b1, 1'b0, 1'b0);
    drive(SW8, 1'b1, 1'b0, 1'b0);
    drive(SW8, 1'b1, 1'b0, 1'b0);
    drive(LW8, 1'b1, 1'b0, 1'b0);
    drive(BEQ8, 1'b1, 1'b0, 1'b0);
    drive(BEQ8, 1'b1, 1'b0, 1'b0);
    drive(LW0, 1'b1, 1'b0, 1'b0);
    drive(r_add(5'd5, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0);
    chk("lw_r0_no_stall", 64'(ifa.pc_write), 64'd1);
    drive(LW8, 1'b1, 1'b0, 1'b0);
    drive(ADD98, 1'b1, 1'b0, 1'b0);
    drive(ADD98, 1'b1, 1'b1, 1'b0);
    drive(ADD312, 1'b1, 1'b1, 1'b0);
    chk("br_in_flush", 64'({ifa.ifid_flush, ifa.ctrl_WB}), 64'({1'b1, 2'b00}));
    repeat (4) drive(ADD312, 1'b1, 1'b0, 1'b0);

    // 6: 3 load-use stalls + branch with flush bubbles, counted from reset
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(LW8, 1'b1, 1'b0, 1'b0);
      drive(ADD98, 1'b1, 1'b0, 1'b0);
      drive(ADD98, 1'b1, 1'b0, 1'b0);
    end
    drive(ADD312, 1'b1, 1'b1, 1'b0);
    drive(ADD312, 1'b1, 1'b0, 1'b0);
    drive(ADD312, 1'b1, 1'b0, 1'b0);
`ifdef ISSUE_STALL_CNT_EN
    chk("cnt_a_five", 64'(ifa.stall_cnt), 64'd5);
    chk("cnt_b_sat", 64'(ifb.stall_cnt), 64'd3);
`else
    chk("cnt_a_tied", 64'(ifa.stall_cnt), 64'd0);
    chk("cnt_b_tied", 64'(ifb.stall_cnt), 64'd0);
`endif
    repeat (3) drive(ADD312, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
